jtdd_snd_romarb: RTL and testbench

Arbiter that shares one 8-bit SDRAM read port among the three sound-subsystem ROM clients: the sound CPU program ROM and the two ADPCM sample ROMs. It sits between the sound block's `rom_*` / `adpcm0_*` / `adpcm1_*` ports and a single SDRAM slot. Each client gets a one-byte tag cache, so a repeated read of the same address answers without touching SDRAM. The CPU has fixed top priority; the two ADPCM channels alternate round-robin.

---
 rtl/jtdd_snd_romarb.sv | 191 +++++++++++++++++++
 tb/tb_jtdd_snd_romarb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_snd_romarb.sv
// Sound ROM arbiter: three clients (CPU, ADPCM0, ADPCM1) share one 8-bit
// SDRAM read port. Each client owns a one-byte tag cache. The CPU always wins;
// the two ADPCM channels alternate when both are waiting.

// One-entry tag cache for a single client. Filled only by the arbiter; the
// valid bit is never cleared except by reset because ROM contents are static.
module jtdd_snd_romarb_cache #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cs,
  input  logic [W-1:0] addr,
  input  logic         fill,
  input  logic [W-1:0] fill_addr,
  input  logic [7:0]   fill_data,
  output logic [7:0]   data,
  output logic         ok,
  output logic         miss
);
  logic [W-1:0] tag_q, tag_d;
  logic [7:0]   data_q, data_d;
  logic         valid_q, valid_d;
  logic         hit;

  // Hit uses the pre-edge tag, so a fill is visible one cycle later
  assign hit  = valid_q & (addr == tag_q);
  assign ok   = cs & hit;
  assign miss = cs & ~hit;
  assign data = data_q;

  // Load tag/data from the fetched address when the arbiter completes a fill
  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (fill) begin
      tag_d   = fill_addr;
      data_d  = fill_data;
      valid_d = 1'b1;
    end
  end

  // Cache registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

module jtdd_snd_romarb #(
  parameter int            AW         = 18,
  parameter logic [AW-1:0] CPU_OFFSET = 18'h00000,
  parameter logic [AW-1:0] AD0_OFFSET = 18'h10000,
  parameter logic [AW-1:0] AD1_OFFSET = 18'h20000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [14:0]   cpu_addr,
  input  logic          cpu_cs,
  output logic [7:0]    cpu_data,
  output logic          cpu_ok,
  input  logic [15:0]   ad0_addr,
  input  logic          ad0_cs,
  output logic [7:0]    ad0_data,
  output logic          ad0_ok,
  input  logic [15:0]   ad1_addr,
  input  logic          ad1_cs,
  output logic [7:0]    ad1_data,
  output logic          ad1_ok,
  output logic [AW-1:0] mem_addr,
  output logic          mem_cs,
  input  logic [7:0]    mem_data,
  input  logic          mem_ok
);
  localparam int NCLI = 3;  // 0 = CPU, 1 = ADPCM0, 2 = ADPCM1

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           rr_q, rr_d;      // 0: ADPCM0 favoured on a tie
  logic           mem_cs_q, mem_cs_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [15:0]    fetch_q, fetch_d;

  // CPU address is zero-extended so all clients share one 16-bit cache shape
  logic [NCLI-1:0][15:0] cli_addr;
  logic [NCLI-1:0]       cli_cs, cli_ok, cli_miss, cli_fill;
  logic [NCLI-1:0][7:0]  cli_data;
  logic [AW-1:0]         offset;

  assign cli_addr = {ad1_addr, ad0_addr, {1'b0, cpu_addr}};
  assign cli_cs   = {ad1_cs, ad0_cs, cpu_cs};

  generate
    for (genvar i = 0; i < NCLI; i++) begin : g_cli
      assign cli_fill[i] = (state_q == S_WAIT) & mem_ok & (gnt_q == 2'(i));
      jtdd_snd_romarb_cache #(.W(16)) u_cache (
        .clk       (clk),
        .rstn      (rstn),
        .cs        (cli_cs[i]),
        .addr      (cli_addr[i]),
        .fill      (cli_fill[i]),
        .fill_addr (fetch_q),
        .fill_data (mem_data),
        .data      (cli_data[i]),
        .ok        (cli_ok[i]),
        .miss      (cli_miss[i])
      );
    end
  endgenerate

  assign {ad1_ok, ad0_ok, cpu_ok} = cli_ok;
  assign cpu_data = cli_data[0];
  assign ad0_data = cli_data[1];
  assign ad1_data = cli_data[2];
  assign mem_cs   = mem_cs_q;
  assign mem_addr = mem_addr_q;

  // Next-state logic: grant in IDLE, skip possibly stale mem_ok in SETTLE,
  // complete in WAIT on mem_ok
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    mem_cs_d   = mem_cs_q;
    mem_addr_d = mem_addr_q;
    fetch_d    = fetch_q;
    offset     = CPU_OFFSET;
    case (state_q)
      S_IDLE: begin
        if (|cli_miss) begin
          if (cli_miss[0]) begin
            gnt_d  = 2'd0;
            offset = CPU_OFFSET;
          end else if (cli_miss[1] && (!cli_miss[2] || !rr_q)) begin
            gnt_d  = 2'd1;
            offset = AD0_OFFSET;
            rr_d   = 1'b1;
          end else begin
            gnt_d  = 2'd2;
            offset = AD1_OFFSET;
            rr_d   = 1'b0;
          end
          fetch_d    = cli_addr[gnt_d];
          mem_addr_d = offset + {{(AW-16){1'b0}}, cli_addr[gnt_d]};
          mem_cs_d   = 1'b1;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ok) begin
          mem_cs_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        mem_cs_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Arbiter state and registered SDRAM request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'd0;
      rr_q       <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_addr_q <= '0;
      fetch_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      mem_cs_q   <= mem_cs_d;
      mem_addr_q <= mem_addr_d;
      fetch_q    <= fetch_d;
    end
  end
endmodule

// File: tb/tb_jtdd_snd_romarb.sv
// Bench for jtdd_snd_romarb: a cycle table for reset, CPU miss/hit and the
// three-way miss, then hand sequences for round-robin, mid-fetch address
// change and reset during WAIT.
module tb_jtdd_snd_romarb;
  logic        clk = 1'b0;
  logic        rstn;
  logic [14:0] cpu_addr;
  logic        cpu_cs;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic [15:0] ad0_addr, ad1_addr;
  logic        ad0_cs, ad1_cs;
  logic [7:0]  ad0_data, ad1_data;
  logic        ad0_ok, ad1_ok;
  logic [17:0] mem_addr;
  logic        mem_cs;
  logic [7:0]  mem_data;
  logic        mem_ok;

  int checks = 0;
  int errors = 0;
  int row    = 0;

  always #5 clk = ~clk;

  jtdd_snd_romarb dut (
    .clk(clk), .rstn(rstn),
    .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .ad0_addr(ad0_addr), .ad0_cs(ad0_cs), .ad0_data(ad0_data), .ad0_ok(ad0_ok),
    .ad1_addr(ad1_addr), .ad1_cs(ad1_cs), .ad1_data(ad1_data), .ad1_ok(ad1_ok),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_data(mem_data), .mem_ok(mem_ok)
  );

  typedef struct {
    logic        rstn;
    logic        cpu_cs;
    logic [14:0] cpu_addr;
    logic        ad0_cs;
    logic [15:0] ad0_addr;
    logic        ad1_cs;
    logic [15:0] ad1_addr;
    logic        mem_ok;
    logic [7:0]  mem_data;
    logic        e_cs;
    logic [17:0] e_addr;
    logic [2:0]  e_ok;   // {ad1, ad0, cpu}
    logic [7:0]  e_cd, e_d0, e_d1;
  } vec_t;

  vec_t vec[18];

  function automatic vec_t mk(logic r, logic cc, logic [14:0] ca, logic c0, logic [15:0] a0,
                              logic c1, logic [15:0] a1, logic mo, logic [7:0] md,
                              logic ecs, logic [17:0] ea, logic [2:0] eok,
                              logic [7:0] ecd, logic [7:0] ed0, logic [7:0] ed1);
    vec_t v;
    v.rstn = r; v.cpu_cs = cc; v.cpu_addr = ca; v.ad0_cs = c0; v.ad0_addr = a0;
    v.ad1_cs = c1; v.ad1_addr = a1; v.mem_ok = mo; v.mem_data = md;
    v.e_cs = ecs; v.e_addr = ea; v.e_ok = eok; v.e_cd = ecd; v.e_d0 = ed0; v.e_d1 = ed1;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until mem_cs is seen (i.e. the SETTLE cycle), bounded
  task automatic wait_cs(output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (mem_cs) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_cs (row %0d): got timeout want mem_cs", row);
    end
  endtask

  initial begin
    bit got;
    logic [7:0] d;
    rstn = 1'b0; cpu_cs = 1'b0; cpu_addr = '0; ad0_cs = 1'b0; ad0_addr = '0;
    ad1_cs = 1'b0; ad1_addr = '0; mem_ok = 1'b0; mem_data = '0;

    //          rst cc  ca       c0  a0        c1  a1        mo   md     cs  addr       ok     cd     d0     d1
    vec[0]  = mk(0, 1, 15'h1234, 1, 16'h0500, 1, 16'h0600, 0, 8'h00,  0, 18'h00000, 3'b000, 8'h00, 8'h00, 8'h00);
    vec[1]  = mk(1, 1, 15'h1234, 1, 16'h0500, 1, 16'h0600, 0, 8'h00,  0, 18'h00000, 3'b000, 8'h00, 8'h00, 8'h00);
    vec[2]  = mk(1, 1, 15'h1234, 0, 16'h0500, 0, 16'h0600, 0, 8'h00,  1, 18'h01234, 3'b000, 8'h00, 8'h00, 8'h00);
    vec[3]  = mk(1, 1, 15'h1234, 0, 16'h0500, 0, 16'h0600, 1, 8'hA5,  1, 18'h01234, 3'b000, 8'h00, 8'h00, 8'h00);
    vec[4]  = mk(1, 1, 15'h1234, 0, 16'h0500, 0, 16'h0600, 0, 8'h00,  0, 18'h01234, 3'b001, 8'hA5, 8'h00, 8'h00);
    vec[5]  = mk(1, 1, 15'h1234, 0, 16'h0500, 0, 16'h0600, 0, 8'h00,  0, 18'h01234, 3'b001, 8'hA5, 8'h00, 8'h00);
    vec[6]  = mk(1, 0, 15'h1234, 0, 16'h0500, 0, 16'h0600, 0, 8'h00,  0, 18'h01234, 3'b000, 8'hA5, 8'h00, 8'h00);
    vec[7]  = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 0, 8'h00,  0, 18'h01234, 3'b000, 8'hA5, 8'h00, 8'h00);
    vec[8]  = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 1, 8'hEE,  1, 18'h00010, 3'b000, 8'hA5, 8'h00, 8'h00);
    vec[9]  = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 1, 8'h11,  1, 18'h00010, 3'b000, 8'hA5, 8'h00, 8'h00);
    vec[10] = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 0, 8'h00,  0, 18'h00010, 3'b001, 8'h11, 8'h00, 8'h00);
    vec[11] = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 0, 8'h00,  1, 18'h10020, 3'b001, 8'h11, 8'h00, 8'h00);
    vec[12] = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 1, 8'h22,  1, 18'h10020, 3'b001, 8'h11, 8'h00, 8'h00);
    vec[13] = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 0, 8'h00,  0, 18'h10020, 3'b011, 8'h11, 8'h22, 8'h00);
    vec[14] = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 0, 8'h00,  1, 18'h20030, 3'b011, 8'h11, 8'h22, 8'h00);
    vec[15] = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 0, 8'h00,  1, 18'h20030, 3'b011, 8'h11, 8'h22, 8'h00);
    vec[16] = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 1, 8'h33,  1, 18'h20030, 3'b011, 8'h11, 8'h22, 8'h00);
    vec[17] = mk(1, 1, 15'h0010, 1, 16'h0020, 1, 16'h0030, 0, 8'h00,  0, 18'h20030, 3'b111, 8'h11, 8'h22, 8'h33);

    for (int i = 0; i < 18; i++) begin
      cyc();
      row = i;
      rstn = vec[i].rstn; cpu_cs = vec[i].cpu_cs; cpu_addr = vec[i].cpu_addr;
      ad0_cs = vec[i].ad0_cs; ad0_addr = vec[i].ad0_addr;
      ad1_cs = vec[i].ad1_cs; ad1_addr = vec[i].ad1_addr;
      mem_ok = vec[i].mem_ok; mem_data = vec[i].mem_data;
      @(negedge clk);
      chk("mem_cs",   32'(mem_cs),   32'(vec[i].e_cs));
      chk("mem_addr", 32'(mem_addr), 32'(vec[i].e_addr));
      chk("cpu_ok",   32'(cpu_ok),   32'(vec[i].e_ok[0]));
      chk("ad0_ok",   32'(ad0_ok),   32'(vec[i].e_ok[1]));
      chk("ad1_ok",   32'(ad1_ok),   32'(vec[i].e_ok[2]));
      chk("cpu_data", 32'(cpu_data), 32'(vec[i].e_cd));
      chk("ad0_data", 32'(ad0_data), 32'(vec[i].e_d0));
      chk("ad1_data", 32'(ad1_data), 32'(vec[i].e_d1));
    end

    // Round-robin: both ADPCM channels keep missing; grants must alternate
    row = 100;
    cyc();
    cpu_cs = 1'b0;
    ad0_addr = 16'h0100;
    ad1_addr = 16'h0200;
    for (int g = 0; g < 4; g++) begin
      row = 100 + g;
      wait_cs(got);
      if ((g % 2) == 0) chk("rr_addr", 32'(mem_addr), 32'(18'h10000 + {2'b00, ad0_addr}));
      else              chk("rr_addr", 32'(mem_addr), 32'(18'h20000 + {2'b00, ad1_addr}));
      cyc();
      d = 8'h40 + 8'(g);
      mem_ok = 1'b1; mem_data = d;
      cyc();
      mem_ok = 1'b0;
      #1;
      if ((g % 2) == 0) begin
        chk("rr_ok0", 32'(ad0_ok), 32'd1);
        chk("rr_d0",  32'(ad0_data), 32'(d));
        ad0_addr = ad0_addr + 16'd1;
      end else begin
        chk("rr_ok1", 32'(ad1_ok), 32'd1);
        chk("rr_d1",  32'(ad1_data), 32'(d));
        ad1_addr = ad1_addr + 16'd1;
      end
    end

    // Mid-fetch address change: fill is tagged with the fetched address
    row = 200;
    ad0_cs = 1'b0;
    ad1_addr = 16'h0040;
    wait_cs(got);
    chk("mf_addr0", 32'(mem_addr), 32'h20040);
    cyc();
    ad1_addr = 16'h0041;
    mem_ok = 1'b1; mem_data = 8'h5A;
    cyc();
    mem_ok = 1'b0;
    #1;
    chk("mf_ok_low", 32'(ad1_ok), 32'd0);
    chk("mf_data",   32'(ad1_data), 32'h5A);
    wait_cs(got);
    chk("mf_addr1", 32'(mem_addr), 32'h20041);
    cyc();
    mem_ok = 1'b1; mem_data = 8'h5B;
    cyc();
    mem_ok = 1'b0;
    #1;
    chk("mf_ok_hi", 32'(ad1_ok), 32'd1);
    chk("mf_data1", 32'(ad1_data), 32'h5B);

    // Reset pulse during WAIT: mem_cs drops immediately, caches invalid
    row = 300;
    ad1_cs = 1'b0;
    cpu_cs = 1'b1; cpu_addr = 15'h7000;
    wait_cs(got);
    chk("rst_addr", 32'(mem_addr), 32'h07000);
    cyc();
    chk("rst_wait_cs", 32'(mem_cs), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_cs",    32'(mem_cs),   32'd0);
    chk("rst_addr0", 32'(mem_addr), 32'd0);
    chk("rst_cd",    32'(cpu_data), 32'd0);
    chk("rst_d1",    32'(ad1_data), 32'd0);
    ad1_cs = 1'b1;
    #1;
    chk("rst_ok1", 32'(ad1_ok), 32'd0);
    cpu_cs = 1'b0; ad1_cs = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
    chk("rst_idle_cs", 32'(mem_cs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
